// File: rtl/i2s_xmit.sv
// I2S master transmitter: 24-bit L/R pairs in over valid/ready, Philips-format bck/lrck/sdata out.
// Optional I2S_REPEAT_ON_UNDERRUN_EN replays the last pair instead of zeros on underrun.
module i2s_xmit #(
  parameter int DATA_W    = 24,
  parameter int BCK_DIV   = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic              mck,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              bck,
  output logic              lrck,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int CNT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               bck_q, bck_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic               frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic               hold_full_q, hold_full_d;
  logic [DATA_W-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0]  sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_W-1:0]  fill_l_s, fill_r_s;
  logic               load_s;

`ifdef I2S_REPEAT_ON_UNDERRUN_EN
  logic [DATA_W-1:0]  last_l_q, last_l_d, last_r_q, last_r_d;

  // Remember the pair most recently taken from the holding register
  always_comb begin
    last_l_d = last_l_q;
    last_r_d = last_r_q;
    if (load_s && hold_full_q) begin
      last_l_d = hold_l_q;
      last_r_d = hold_r_q;
    end else begin
      last_l_d = last_l_q;
      last_r_d = last_r_q;
    end
  end

  // Last-pair register
  always_ff @(posedge mck) begin
    if (rst) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
    end
  end

  assign fill_l_s = last_l_q;
  assign fill_r_s = last_r_q;
`else
  assign fill_l_s = '0;
  assign fill_r_s = '0;
`endif

  // Next-state: clock division, slot sequencing, frame load and holding register
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bck_d         = bck_q;
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    sh_l_d        = sh_l_q;
    sh_r_d        = sh_r_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    load_s        = 1'b0;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bck_d     = 1'b0;
        lrck_d    = 1'b0;
        sdata_d   = 1'b0;
        if (en) begin
          load_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d   = IDLE;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          bck_d     = 1'b0;
          lrck_d    = 1'b0;
          sdata_d   = 1'b0;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          bck_d     = !bck_q;
          // bck falling: start the next bit period
          if (bck_q) begin
            if (bit_cnt_q == SLOT_LAST) begin
              bit_cnt_d = '0;
              lrck_d    = !lrck_q;
              sdata_d   = 1'b0;
              load_s    = lrck_q;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q < DATA_END) begin
                if (lrck_q) begin
                  sdata_d = sh_r_q[DATA_W-1];
                  sh_r_d  = {sh_r_q[DATA_W-2:0], 1'b0};
                end else begin
                  sdata_d = sh_l_q[DATA_W-1];
                  sh_l_d  = {sh_l_q[DATA_W-2:0], 1'b0};
                end
              end else begin
                sdata_d = 1'b0;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bck_d     = 1'b0;
        lrck_d    = 1'b0;
        sdata_d   = 1'b0;
      end
    endcase

    if (load_s) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        sh_l_d = hold_l_q;
        sh_r_d = hold_r_q;
      end else begin
        sh_l_d     = fill_l_s;
        sh_r_d     = fill_r_s;
        underrun_d = 1'b1;
      end
    end else begin
      frame_start_d = 1'b0;
    end

    // A same-cycle handshake is impossible while a held pair is being loaded
    if (load_s && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (in_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = in_left;
      hold_r_d    = in_right;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge mck) begin
    if (rst) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      bck_q         <= 1'b0;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bck_q         <= bck_d;
      lrck_q        <= lrck_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
    end
  end

  assign in_ready    = !hold_full_q;
  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_xmit.sv
// Bench for i2s_xmit: frame-position reference model checked every mck, plus directed literal checks.
module tb_i2s_xmit;
  localparam int DATA_W    = 24;
  localparam int BCK_DIV   = 16;
  localparam int SLOT_BITS = 32;
  localparam int PER       = 2 * BCK_DIV;
  localparam int FRAME     = 2 * SLOT_BITS * PER;

  logic              mck = 1'b0;
  logic              rst, en, in_valid;
  logic              in_ready, bck, lrck, sdata, frame_start, underrun;
  logic [DATA_W-1:0] in_left, in_right;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit rnd_done = 1'b0;

  always #5 mck = ~mck;

  i2s_xmit #(.DATA_W(DATA_W), .BCK_DIV(BCK_DIV), .SLOT_BITS(SLOT_BITS)) dut (
    .mck(mck), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .bck(bck), .lrck(lrck), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position t within the frame decides every output
  bit                m_run = 1'b0, m_under = 1'b0, m_hfull = 1'b0;
  int                m_t = 0, mq, mp;
  logic              mlr, msd;
  logic [DATA_W-1:0] m_cl = '0, m_cr = '0, m_hl = '0, m_hr = '0, m_ll = '0, m_lr = '0, mw;
  logic [5:0]        m_exp = 6'b000001;

  always @(posedge mck) begin
    bit hs, ld;
    hs = in_valid && !m_hfull;
    ld = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_hfull = 1'b0; m_under = 1'b0;
      m_ll = '0; m_lr = '0; m_cl = '0; m_cr = '0;
    end else begin
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_t = 0; ld = 1'b1; end
      end else if (!en) begin
        m_run = 1'b0;
      end else begin
        m_t++;
        if (m_t == FRAME) begin m_t = 0; ld = 1'b1; end
      end
      if (ld) begin
        if (m_hfull) begin
          m_cl = m_hl; m_cr = m_hr; m_ll = m_hl; m_lr = m_hr;
          m_under = 1'b0; m_hfull = 1'b0;
        end else begin
`ifdef I2S_REPEAT_ON_UNDERRUN_EN
          m_cl = m_ll; m_cr = m_lr;
`else
          m_cl = '0; m_cr = '0;
`endif
          m_under = 1'b1;
        end
      end
      if (hs) begin m_hl = in_left; m_hr = in_right; m_hfull = 1'b1; end
    end
    if (m_run) begin
      mq  = m_t / PER;
      mp  = mq % SLOT_BITS;
      mlr = (mq / SLOT_BITS) != 0;
      mw  = mlr ? m_cr : m_cl;
      msd = 1'b0;
      if (mp >= 1 && mp <= DATA_W) msd = mw[DATA_W-mp];
      m_exp = {((m_t / BCK_DIV) % 2) == 1, mlr, msd, m_t == 0, (m_t == 0) && m_under, !m_hfull};
    end else begin
      m_exp = {5'b00000, !m_hfull};
    end
  end

  // Compare process, sampled on the inactive edge
  logic prev_bck = 1'b0, prev_sd = 1'b0;
  always @(negedge mck) begin
    if (chk_en) begin
      check("outputs{bck,lrck,sdata,fs,ur,rdy}",
            64'({bck, lrck, sdata, frame_start, underrun, in_ready}), 64'(m_exp));
      if (!prev_bck && bck) check("sdata_stable_at_bck_rise", 64'(sdata), 64'(prev_sd));
    end
    prev_bck = bck;
    prev_sd  = sdata;
  end

  task automatic tick();
    @(posedge mck);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    bit acc;
    int n;
    in_left = l; in_right = r; in_valid = 1'b1; acc = 1'b0; n = 0;
    while (!acc && n < 3 * FRAME) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(acc), 64'(1));
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 3 * FRAME) begin
      tick();
      n++;
    end
    check(name, 64'(frame_start), 64'(1));
  endtask

  // Starting on a frame_start sample, read one bit per bck period at mid-period
  task automatic capture(output logic [SLOT_BITS-1:0] l, output logic [SLOT_BITS-1:0] r,
                         output int t_lr, output int t_bck);
    int k;
    l = '0; r = '0; t_lr = -1; t_bck = -1;
    for (int t = 0; t < FRAME; t++) begin
      if (t % PER == BCK_DIV) begin
        k = t / PER;
        if (k < SLOT_BITS) l[SLOT_BITS-1-k] = sdata;
        else               r[2*SLOT_BITS-1-k] = sdata;
      end
      if (lrck === 1'b1 && t_lr < 0)  t_lr = t;
      if (bck === 1'b1 && t_bck < 0)  t_bck = t;
      tick();
    end
  endtask

  function automatic logic [SLOT_BITS-1:0] slot(input logic [DATA_W-1:0] w);
    return {1'b0, w, {(SLOT_BITS-1-DATA_W){1'b0}}};
  endfunction

  initial begin
    logic [SLOT_BITS-1:0] l, r, l2, r2;
    int tlr, tbk, tlr2, tbk2;
    logic [DATA_W-1:0] a_l, a_r, b_l, b_r, c_l, c_r;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    check("reset_state", 64'({bck, lrck, sdata, frame_start, underrun, in_ready}), 64'(6'b000001));

    // Bit pattern and clock timing
    send(24'h800001, 24'h7FFFFF);
    check("ready_low_when_held", 64'(in_ready), 64'(0));
    en = 1'b1;
    wait_fs("first_frame_start");
    check("first_frame_no_underrun", 64'(underrun), 64'(0));
    capture(l, r, tlr, tbk);
    check("left_slot_bits", 64'(l), 64'(32'h4000_0080));
    check("right_slot_bits", 64'(r), 64'(32'h3FFF_FF80));
    check("lrck_half_period", 64'(tlr), 64'(1024));
    check("bck_first_rise", 64'(tbk), 64'(16));
    check("frame_period_2048", 64'(frame_start), 64'(1));
    check("underrun_when_empty", 64'(underrun), 64'(1));
    capture(l, r, tlr, tbk);
`ifdef I2S_REPEAT_ON_UNDERRUN_EN
    check("underrun_left_repeat", 64'(l), 64'(32'h4000_0080));
    check("underrun_right_repeat", 64'(r), 64'(32'h3FFF_FF80));
`else
    check("underrun_left_zero", 64'(l), 64'(0));
    check("underrun_right_zero", 64'(r), 64'(0));
`endif

    // Back-to-back A, B, C
    en = 1'b0;
    tick();
    check("idle_outputs", 64'({bck, lrck, sdata, frame_start, underrun}), 64'(0));
    a_l = 24'h123456; a_r = 24'hFEDCBA;
    b_l = 24'hA5A5A5; b_r = 24'h5A5A5A;
    c_l = 24'h000FFF; c_r = 24'hC00003;
    send(a_l, a_r);
    en = 1'b1;
    fork
      begin
        wait_fs("abc_frame1_start");
        capture(l, r, tlr, tbk);
        check("abc_a_left", 64'(l), 64'(slot(a_l)));
        check("abc_a_right", 64'(r), 64'(slot(a_r)));
        check("abc_frame2_start", 64'(frame_start), 64'(1));
        check("abc_ready_after_load", 64'(in_ready), 64'(1));
        check("abc_frame2_no_underrun", 64'(underrun), 64'(0));
        capture(l2, r2, tlr2, tbk2);
        check("abc_b_left", 64'(l2), 64'(slot(b_l)));
        check("abc_b_right", 64'(r2), 64'(slot(b_r)));
        check("abc_frame3_no_underrun", 64'(underrun), 64'(0));
        capture(l2, r2, tlr2, tbk2);
        check("abc_c_left", 64'(l2), 64'(slot(c_l)));
        check("abc_c_right", 64'(r2), 64'(slot(c_r)));
      end
      begin
        send(b_l, b_r);
        send(c_l, c_r);
      end
    join
    check("abc_frame4_underrun", 64'(underrun), 64'(1));

    // en dropped at bit period 10 of the right slot, pair D held
    send(24'h0F0F0F, 24'h3C3C3C);
    repeat (1348) tick();
    check("in_right_slot", 64'(lrck), 64'(1));
    en = 1'b0;
    tick();
    check("en_drop_outputs", 64'({bck, lrck, sdata}), 64'(0));
    check("en_drop_keeps_hold", 64'(in_ready), 64'(0));
    repeat (5) tick();
    en = 1'b1;
    wait_fs("reenable_frame_start");
    check("reenable_no_underrun", 64'(underrun), 64'(0));
    capture(l, r, tlr, tbk);
    check("held_d_left", 64'(l), 64'(slot(24'h0F0F0F)));
    check("held_d_right", 64'(r), 64'(slot(24'h3C3C3C)));

    // Reset mid left slot with a pair held
    send(24'h777777, 24'h111111);
    repeat (200) tick();
    rst = 1'b1; en = 1'b0;
    tick();
    check("midframe_reset", 64'({bck, lrck, sdata, frame_start, underrun, in_ready}), 64'(6'b000001));
    rst = 1'b0; en = 1'b1;
    wait_fs("post_reset_frame_start");
    check("post_reset_underrun", 64'(underrun), 64'(1));
    capture(l, r, tlr, tbk);
    check("post_reset_left_zero", 64'(l), 64'(0));
    check("post_reset_right_zero", 64'(r), 64'(0));

    // Randomized traffic with one random en blip
    fork
      begin
        repeat (3 * FRAME + $urandom_range(0, FRAME)) tick();
        en = 1'b0;
        repeat ($urandom_range(1, 40)) tick();
        en = 1'b1;
        repeat (3 * FRAME) tick();
        rnd_done = 1'b1;
      end
      begin
        int g;
        while (!rnd_done) begin
          g = $urandom_range(0, 2500);
          for (int i = 0; i < g && !rnd_done; i++) tick();
          if (!rnd_done) send(DATA_W'($urandom()), DATA_W'($urandom()));
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
